// File: rtl/histogram_engine.sv
// Streams packed pixel words from input memory and accumulates a bin-count
// histogram in scratch memory through a read-modify-write pipeline with forwarding.
module histogram_engine #(
    parameter int MEM_W    = 128,
    parameter int PIXEL_W  = 8,
    parameter int COUNT_W  = 32,
    parameter int ADDR_W   = 16,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_first,
    input  logic [ADDR_W-1:0] in_base_addr,
    input  logic [ADDR_W-1:0] in_num_words,
    output logic              busy,
    output logic              done,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [MEM_W-1:0]  in_rdata,
    output logic              scr_rd_en,
    output logic [ADDR_W-1:0] scr_rd_addr,
    input  logic [MEM_W-1:0]  scr_rdata,
    output logic              scr_we,
    output logic [ADDR_W-1:0] scr_waddr,
    output logic [MEM_W-1:0]  scr_wdata
);

    localparam int PPW       = MEM_W / PIXEL_W;
    localparam int BPW       = MEM_W / COUNT_W;
    localparam int SCR_WORDS = (2 ** PIXEL_W) / BPW;
    localparam int LANE_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PC_W      = $clog2(PPW + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   base_reg;
    logic [ADDR_W-1:0]   num_reg;
    logic [ADDR_W-1:0]   widx_reg;
    logic [ADDR_W-1:0]   clr_cnt_reg;
    logic [PC_W-1:0]     pix_cnt_reg;
    logic                drain_cnt_reg;
    logic [MEM_W-1:0]    pix_sh_reg;

    // Pipeline: s1 = issued pixel awaiting scratch data, wr = result on the
    // write port, dly = the write from one cycle earlier (still unseen by reads).
    logic                s1_valid_reg;
    logic [ADDR_W-1:0]   s1_word_reg;
    logic [LANE_W-1:0]   s1_lane_reg;
    logic                wr_valid_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [MEM_W-1:0]    wr_data_reg;
    logic                dly_valid_reg;
    logic [ADDR_W-1:0]   dly_addr_reg;
    logic [MEM_W-1:0]    dly_data_reg;

    logic [PIXEL_W-1:0]  cur_pixel;
    logic [ADDR_W-1:0]   cur_word;
    logic [LANE_W-1:0]   cur_lane;
    logic                last_word;
    logic [MEM_W-1:0]    merge_base;
    logic [MEM_W-1:0]    merged;

    assign cur_pixel = pix_sh_reg[PIXEL_W-1:0];
    assign cur_word  = ADDR_W'(cur_pixel / PIXEL_W'(BPW));
    assign cur_lane  = LANE_W'(cur_pixel % PIXEL_W'(BPW));
    assign last_word = (widx_reg == num_reg - ADDR_W'(1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    if (clear_first)
                        state_next = S_CLEAR;
                    else if (in_num_words == '0)
                        state_next = S_DONE;
                    else
                        state_next = S_FETCH;
                end
            end
            S_CLEAR: begin
                if (clr_cnt_reg == ADDR_W'(SCR_WORDS - 1))
                    state_next = (num_reg == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_ISSUE;
            S_ISSUE: begin
                if (pix_cnt_reg == PC_W'(PPW - 1))
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt_reg)
                    state_next = last_word ? S_DONE : S_FETCH;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            base_reg      <= '0;
            num_reg       <= '0;
            widx_reg      <= '0;
            clr_cnt_reg   <= '0;
            pix_cnt_reg   <= '0;
            drain_cnt_reg <= 1'b0;
            pix_sh_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        base_reg    <= in_base_addr;
                        num_reg     <= in_num_words;
                        widx_reg    <= '0;
                        clr_cnt_reg <= '0;
                    end
                end
                S_CLEAR: clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
                S_WAIT: begin
                    pix_sh_reg  <= in_rdata;
                    pix_cnt_reg <= '0;
                end
                S_ISSUE: begin
                    pix_sh_reg    <= pix_sh_reg >> PIXEL_W;
                    pix_cnt_reg   <= pix_cnt_reg + PC_W'(1);
                    drain_cnt_reg <= 1'b0;
                end
                S_DRAIN: begin
                    drain_cnt_reg <= 1'b1;
                    if (drain_cnt_reg && !last_word)
                        widx_reg <= widx_reg + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_reg  <= 1'b0;
            s1_word_reg   <= '0;
            s1_lane_reg   <= '0;
            wr_valid_reg  <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            dly_valid_reg <= 1'b0;
            dly_addr_reg  <= '0;
            dly_data_reg  <= '0;
        end else begin
            s1_valid_reg  <= (state_reg == S_ISSUE);
            s1_word_reg   <= cur_word;
            s1_lane_reg   <= cur_lane;
            wr_valid_reg  <= s1_valid_reg;
            wr_addr_reg   <= s1_word_reg;
            if (s1_valid_reg)
                wr_data_reg <= merged;
            dly_valid_reg <= wr_valid_reg;
            dly_addr_reg  <= wr_addr_reg;
            dly_data_reg  <= wr_data_reg;
        end
    end

    // The newest in-flight result for the same word wins over memory data.
    always_comb begin
        merge_base = scr_rdata;
        if (wr_valid_reg && (wr_addr_reg == s1_word_reg))
            merge_base = wr_data_reg;
        else if (dly_valid_reg && (dly_addr_reg == s1_word_reg))
            merge_base = dly_data_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            localparam int HI = MEM_W - 1 - gi * COUNT_W;
            logic [COUNT_W-1:0] lane_val;
            logic               lane_inc;
            assign lane_val = merge_base[HI -: COUNT_W];
            assign lane_inc = (s1_lane_reg == LANE_W'(gi)) &&
                              !((SATURATE != 0) && (&lane_val));
            assign merged[HI -: COUNT_W] = lane_inc ? lane_val + COUNT_W'(1) : lane_val;
        end
    endgenerate

    always_comb begin
        busy        = (state_reg != S_IDLE);
        done        = (state_reg == S_DONE);
        in_rd_en    = 1'b0;
        in_addr     = '0;
        scr_rd_en   = 1'b0;
        scr_rd_addr = '0;
        scr_we      = 1'b0;
        scr_waddr   = '0;
        scr_wdata   = '0;
        if (state_reg == S_FETCH) begin
            in_rd_en = 1'b1;
            in_addr  = base_reg + widx_reg;
        end
        if (state_reg == S_ISSUE) begin
            scr_rd_en   = 1'b1;
            scr_rd_addr = cur_word;
        end
        if (state_reg == S_CLEAR) begin
            scr_we    = 1'b1;
            scr_waddr = clr_cnt_reg;
        end else if (wr_valid_reg) begin
            scr_we    = 1'b1;
            scr_waddr = wr_addr_reg;
            scr_wdata = wr_data_reg;
        end
    end

endmodule

// File: tb/tb_histogram_engine.sv
// Scoreboard bench for histogram_engine: one saturating and one wrapping instance
// share stimulus; expected writes, reads and done cycles are queued and popped by a monitor.
module tb_histogram_engine;

    localparam int MEM_W  = 128;
    localparam int ADDR_W = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic clear_first = 1'b0;
    logic [ADDR_W-1:0] in_base_addr = '0;
    logic [ADDR_W-1:0] in_num_words = '0;

    logic busy0, done0, in_rd_en0, scr_rd_en0, scr_we0;
    logic busy1, done1, in_rd_en1, scr_rd_en1, scr_we1;
    logic [ADDR_W-1:0] in_addr0, scr_rd_addr0, scr_waddr0;
    logic [ADDR_W-1:0] in_addr1, scr_rd_addr1, scr_waddr1;
    logic [MEM_W-1:0] in_rdata0, scr_rdata0, scr_wdata0;
    logic [MEM_W-1:0] in_rdata1, scr_rdata1, scr_wdata1;

    logic [MEM_W-1:0] in_mem [32];
    logic [MEM_W-1:0] scr0 [64];
    logic [MEM_W-1:0] scr1 [64];
    logic             pre_en = 1'b0;
    logic [5:0]       pre_addr = '0;
    logic [MEM_W-1:0] pre_data = '0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [MEM_W-1:0]  d_sat;
        logic [MEM_W-1:0]  d_wrap;
    } wr_t;

    wr_t               exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    int                exp_done[$];
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    histogram_engine #(.SATURATE(1)) dut (
        .clock(clock), .reset(reset), .start(start), .clear_first(clear_first),
        .in_base_addr(in_base_addr), .in_num_words(in_num_words),
        .busy(busy0), .done(done0), .in_rd_en(in_rd_en0), .in_addr(in_addr0),
        .in_rdata(in_rdata0), .scr_rd_en(scr_rd_en0), .scr_rd_addr(scr_rd_addr0),
        .scr_rdata(scr_rdata0), .scr_we(scr_we0), .scr_waddr(scr_waddr0),
        .scr_wdata(scr_wdata0)
    );

    histogram_engine #(.SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .start(start), .clear_first(clear_first),
        .in_base_addr(in_base_addr), .in_num_words(in_num_words),
        .busy(busy1), .done(done1), .in_rd_en(in_rd_en1), .in_addr(in_addr1),
        .in_rdata(in_rdata1), .scr_rd_en(scr_rd_en1), .scr_rd_addr(scr_rd_addr1),
        .scr_rdata(scr_rdata1), .scr_we(scr_we1), .scr_waddr(scr_waddr1),
        .scr_wdata(scr_wdata1)
    );

    // Memories: 1-cycle registered reads, read-during-write returns old data.
    always @(posedge clock) begin
        if (pre_en) begin
            scr0[pre_addr] <= pre_data;
            scr1[pre_addr] <= pre_data;
        end
        if (scr_we0) scr0[scr_waddr0[5:0]] <= scr_wdata0;
        if (scr_we1) scr1[scr_waddr1[5:0]] <= scr_wdata1;
        if (scr_rd_en0) scr_rdata0 <= scr0[scr_rd_addr0[5:0]];
        if (scr_rd_en1) scr_rdata1 <= scr1[scr_rd_addr1[5:0]];
        if (in_rd_en0) in_rdata0 <= in_mem[in_addr0[4:0]];
        if (in_rd_en1) in_rdata1 <= in_mem[in_addr1[4:0]];
    end

    // Monitor
    always @(negedge clock) begin
        if (reset) begin
            if (scr_we0 || scr_we1) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%h required no write", scr_waddr0, scr_wdata0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    if (scr_we0 !== 1'b1 || scr_we1 !== 1'b1 || scr_waddr0 !== e.addr ||
                        scr_waddr1 !== e.addr || scr_wdata0 !== e.d_sat || scr_wdata1 !== e.d_wrap) begin
                        errors++;
                        $display("FAIL scr_write got we=%b%b addr=%0h/%0h data=%h/%h required addr=%0h data=%h/%h",
                                 scr_we0, scr_we1, scr_waddr0, scr_waddr1, scr_wdata0, scr_wdata1,
                                 e.addr, e.d_sat, e.d_wrap);
                    end
                end
            end
            if (in_rd_en0 || in_rd_en1) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read in_addr=%0h required no read", in_addr0);
                end else begin
                    logic [ADDR_W-1:0] a;
                    a = exp_rd.pop_front();
                    if (in_rd_en0 !== 1'b1 || in_rd_en1 !== 1'b1 || in_addr0 !== a || in_addr1 !== a) begin
                        errors++;
                        $display("FAIL in_read got en=%b%b addr=%0h/%0h required addr=%0h",
                                 in_rd_en0, in_rd_en1, in_addr0, in_addr1, a);
                    end
                end
            end
            if (done0 || done1) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cycle=%0d required no done", cyc);
                end else begin
                    int c;
                    c = exp_done.pop_front();
                    if (done0 !== 1'b1 || done1 !== 1'b1 || cyc != c) begin
                        errors++;
                        $display("FAIL done_timing got done=%b%b cycle=%0d required cycle=%0d",
                                 done0, done1, cyc, c);
                    end
                end
            end
        end
    end

    function automatic logic [MEM_W-1:0] put(input logic [MEM_W-1:0] w, input int lane,
                                             input logic [31:0] v);
        w[MEM_W-1-32*lane -: 32] = v;
        return w;
    endfunction

    task automatic push_wr(input int addr, input logic [MEM_W-1:0] ds, input logic [MEM_W-1:0] dw);
        wr_t e;
        e.addr   = ADDR_W'(addr);
        e.d_sat  = ds;
        e.d_wrap = dw;
        exp_wr.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < 64; i++) push_wr(i, '0, '0);
    endtask

    task automatic flush();
        exp_wr.delete();
        exp_rd.delete();
        exp_done.delete();
    endtask

    task automatic run(input logic clr, input int base, input int nw, input int done_off);
        @(negedge clock);
        for (int i = 0; i < nw; i++) exp_rd.push_back(ADDR_W'(base + i));
        exp_done.push_back(cyc + done_off);
        start        = 1'b1;
        clear_first  = clr;
        in_base_addr = ADDR_W'(base);
        in_num_words = ADDR_W'(nw);
        @(negedge clock);
        start        = 1'b0;
        clear_first  = 1'b0;
        in_base_addr = '0;
        in_num_words = '0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_done.size() != 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_timeout pending wr=%0d rd=%0d done=%0d required all 0",
                     name, exp_wr.size(), exp_rd.size(), exp_done.size());
            flush();
        end
        repeat (2) @(negedge clock);
        $display("RUN %s complete at cycle %0d", name, cyc);
    endtask

    task automatic check_word(input string name, input logic [MEM_W-1:0] got, input logic [MEM_W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        logic [180:0] v0, v1;
        v0 = {busy0, done0, in_rd_en0, in_addr0, scr_rd_en0, scr_rd_addr0, scr_we0, scr_waddr0, scr_wdata0};
        v1 = {busy1, done1, in_rd_en1, in_addr1, scr_rd_en1, scr_rd_addr1, scr_we1, scr_waddr1, scr_wdata1};
        checks += 2;
        if (v0 !== '0) begin
            errors++;
            $display("FAIL %s_sat outputs=%h required 0", name, v0);
        end
        if (v1 !== '0) begin
            errors++;
            $display("FAIL %s_wrap outputs=%h required 0", name, v1);
        end
    endtask

    initial begin
        int n;
        in_mem[0]  = '0;
        in_mem[1]  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        in_mem[2]  = 128'h09050905_09050905_09050905_09050905;
        in_mem[5]  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF1111;
        in_mem[16] = '0;
        in_mem[17] = 128'h01010101_01010101_01010101_01010101;
        in_mem[18] = '0;

        repeat (3) @(negedge clock);
        check_zero("reset_state");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Reset asserted mid-ISSUE abandons the run immediately
        push_clear();
        for (int k = 1; k <= 16; k++) push_wr(0, put('0, 0, k), put('0, 0, k));
        run(1'b1, 0, 1, 85);
        n = 0;
        while (scr_rd_en0 !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL issue_reached got scr_rd_en=%b required 1", scr_rd_en0);
        end
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_zero("reset_mid_issue");
        flush();
        @(negedge clock);
        check_zero("reset_held");
        reset = 1'b1;
        $display("RUN reset_mid_issue complete at cycle %0d", cyc);

        // Same bin: sixteen 0x00 pixels forward back to back into lane 0
        push_clear();
        for (int k = 1; k <= 16; k++) push_wr(0, put('0, 0, k), put('0, 0, k));
        run(1'b1, 0, 1, 85);
        wait_quiet("same_bin");
        check_word("same_bin_w0", scr0[0], put('0, 0, 16));
        check_word("same_bin_w1", scr0[1], '0);
        check_word("same_bin_w63", scr0[63], '0);

        // Distinct bins 0x00..0x0F
        push_clear();
        for (int p = 0; p < 16; p++) begin
            logic [MEM_W-1:0] d;
            d = '0;
            for (int l = 0; l <= p % 4; l++) d = put(d, l, 1);
            push_wr(p / 4, d, d);
        end
        run(1'b1, 1, 1, 85);
        wait_quiet("distinct_bins");
        for (int w = 0; w < 4; w++)
            check_word("distinct_final", scr0[w], 128'h00000001_00000001_00000001_00000001);

        // Distance-2 hazard: 0x05,0x09 alternating
        push_clear();
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) push_wr(1, put('0, 1, k / 2 + 1), put('0, 1, k / 2 + 1));
            else            push_wr(2, put('0, 1, k / 2 + 1), put('0, 1, k / 2 + 1));
        end
        run(1'b1, 2, 1, 85);
        wait_quiet("distance2");
        check_word("distance2_w1", scr0[1], put('0, 1, 8));
        check_word("distance2_w2", scr0[2], put('0, 1, 8));

        // Multi-word run with start pulses while busy
        push_clear();
        for (int k = 1; k <= 16; k++) push_wr(0, put('0, 0, k), put('0, 0, k));
        for (int k = 1; k <= 16; k++) push_wr(0, put(put('0, 0, 16), 1, k), put(put('0, 0, 16), 1, k));
        for (int k = 1; k <= 16; k++) push_wr(0, put(put('0, 0, 16 + k), 1, 16), put(put('0, 0, 16 + k), 1, 16));
        run(1'b1, 16, 3, 125);
        for (int j = 0; j < 4; j++) begin
            repeat (17) @(negedge clock);
            start        = 1'b1;
            clear_first  = 1'b0;
            in_base_addr = 16'h001F;
            in_num_words = 16'd1;
            @(negedge clock);
            start = 1'b0;
        end
        in_base_addr = '0;
        in_num_words = '0;
        wait_quiet("multi_word");
        check_word("multi_word_w0", scr0[0], put(put('0, 0, 32), 1, 16));

        // Saturate vs wrap on preloaded bin 0x11
        @(negedge clock);
        pre_en   = 1'b1;
        pre_addr = 6'd4;
        pre_data = put('0, 1, 32'hFFFFFFFE);
        @(negedge clock);
        pre_en = 1'b0;
        push_wr(4, put('0, 1, 32'hFFFFFFFF), put('0, 1, 32'hFFFFFFFF));
        push_wr(4, put('0, 1, 32'hFFFFFFFF), '0);
        for (int k = 1; k <= 14; k++) push_wr(63, put('0, 3, k), put('0, 3, k));
        run(1'b0, 5, 1, 21);
        wait_quiet("saturate_wrap");
        check_word("sat_final", scr0[4], put('0, 1, 32'hFFFFFFFF));
        check_word("wrap_final", scr1[4], '0);
        check_word("sat_w63", scr0[63], put('0, 3, 14));

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
